lfsr_checker: RTL

//  Receive-side checker for the team's 32-bit XNOR LFSR stream (taps 32,22,2,1, zero-word insertion).

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/lfsr_predict.sv | 33 +++
 rtl/lfsr_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit XNOR LFSR stream (taps 32,22,2,1 with
// zero-word insertion). Both the generator and the receive-side checker use
// lfsr_step() so the two ends cannot drift apart.
//   LFSR_W       word width
//   TAP_*        0-based bit indices of the feedback taps
//   INS_TRIGGER  word whose arrival is preceded by an inserted all-zero word
//   chk_state_e  checker acquisition state
package lfsr_pkg;

  localparam int LFSR_W = 32;

  // Taps 32,22,2,1 expressed as 0-based bit positions.
  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] INS_TRIGGER = 32'h0000_0003;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } chk_state_e;

  // One raw shift of the XNOR LFSR, without zero-word insertion.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ~(x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D])};
  endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Combinational predictor advance for the LFSR stream including the
// zero-word insertion rule.
//   word          word to advance from (last seen or last predicted)
//   ins_pend      an inserted zero was the previous prediction; 0x3 follows
//   exp_next      predicted next word
//   ins_pend_next set when exp_next is the inserted zero word
module lfsr_predict
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] word,
  input  logic              ins_pend,
  output logic [LFSR_W-1:0] exp_next,
  output logic              ins_pend_next
);

  logic [LFSR_W-1:0] stepped;

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can
    // leave a value unassigned and infer a latch.
    stepped       = lfsr_step(word);
    exp_next      = stepped;
    ins_pend_next = 1'b0;
    if (ins_pend) begin
      // The zero was already emitted; the word it displaced comes now.
      exp_next = INS_TRIGGER;
    end else if (stepped == INS_TRIGGER) begin
      exp_next      = '0;
      ins_pend_next = 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the LFSR word stream. Seeds a predictor from the
// incoming words, confirms LOCK_COUNT further matches, then free-runs the
// predictor (flywheel) and counts mismatching words and bits.
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   valid      din carries a word this cycle
//   din        word under test
//   clr        synchronous clear of err_words / err_bits (lock untouched)
//   locked     high while in the LOCKED state
//   err_pulse  one-cycle pulse after a mismatching word while LOCKED
//   err_words  saturating count of mismatching words while LOCKED
//   err_bits   saturating sum of differing bits over those words
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [LFSR_W-1:0] din,
  input  logic              clr,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_words,
  output logic [CNT_W-1:0]  err_bits
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
  localparam int POP_W   = $clog2(LFSR_W + 1);
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_COUNT);

  function automatic logic [POP_W-1:0] popcount(input logic [LFSR_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < LFSR_W; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  chk_state_e         state, state_next;
  logic [LFSR_W-1:0]  exp_word;
  logic               ins_pend;
  logic [MATCH_W-1:0] match_cnt, match_next;
  logic [MISS_W-1:0]  miss_cnt, miss_next;

  logic               use_din;    // advance from the received word (seeding)
  logic               load_pred;  // capture the predictor output this cycle
  logic               hit_err;    // mismatching word while LOCKED
  logic [LFSR_W-1:0]  pred_word;
  logic               pred_pend;
  logic [LFSR_W-1:0]  pred_exp;
  logic               pred_pend_next;
  logic [CNT_W:0]     bits_sum;

  lfsr_predict u_predict (
    .word          (pred_word),
    .ins_pend      (pred_pend),
    .exp_next      (pred_exp),
    .ins_pend_next (pred_pend_next)
  );

  always_comb begin
    state_next = state;
    match_next = match_cnt;
    miss_next  = miss_cnt;
    use_din    = 1'b0;
    load_pred  = 1'b0;
    hit_err    = 1'b0;
    if (valid) begin
      unique case (state)
        SEARCH: begin
          // A zero word is ambiguous (possibly an insertion) so never seeds.
          if (din != '0) begin
            use_din    = 1'b1;
            load_pred  = 1'b1;
            match_next = '0;
            state_next = VERIFY;
          end
        end
        VERIFY: begin
          if (din == exp_word) begin
            load_pred  = 1'b1;
            match_next = match_cnt + 1'b1;
            if (match_next == LOCK_LAST) begin
              state_next = LOCKED;
              miss_next  = '0;
            end
          end else if (din != '0) begin
            use_din    = 1'b1;
            load_pred  = 1'b1;
            match_next = '0;
          end else begin
            match_next = '0;
            state_next = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction never follows din once locked.
          load_pred = 1'b1;
          if (din != exp_word) begin
            hit_err   = 1'b1;
            miss_next = miss_cnt + 1'b1;
            if (miss_next == LOSS_LAST) begin
              state_next = SEARCH;
              miss_next  = '0;
              match_next = '0;
            end
          end else begin
            miss_next = '0;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
    pred_word = use_din ? din : exp_word;
    pred_pend = use_din ? 1'b0 : ins_pend;
    bits_sum  = {1'b0, err_bits} + (CNT_W+1)'(popcount(din ^ exp_word));
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= SEARCH;
      exp_word  <= '0;
      ins_pend  <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_words <= '0;
      err_bits  <= '0;
    end else begin
      state     <= state_next;
      match_cnt <= match_next;
      miss_cnt  <= miss_next;
      if (load_pred) begin
        exp_word <= pred_exp;
        ins_pend <= pred_pend_next;
      end
      locked    <= (state_next == LOCKED);
      err_pulse <= hit_err;
      // Clear takes priority over a simultaneous error; the pulse still fires.
      if (clr) begin
        err_words <= '0;
        err_bits  <= '0;
      end else if (hit_err) begin
        if (!(&err_words)) err_words <= err_words + 1'b1;
        err_bits <= bits_sum[CNT_W] ? {CNT_W{1'b1}} : bits_sum[CNT_W-1:0];
      end
    end
  end

endmodule
